// File: rtl/load_store_unit.sv
// load_store_unit -- memory stage of the RV32I core.
//
// Executes one load or store at a time over an ack-based data bus. Loads are
// lane-aligned, sign- or zero-extended and written back as a single-cycle
// register-file write. Misaligned accesses, illegal funct3 values and bus
// timeouts end in a one-cycle fault pulse instead of a bus access.
//
// Handshakes:
//   request : a request transfers on a posedge where req_valid && req_ready.
//             req_ready is high exactly when the unit is IDLE.
//   bus     : bus_read/bus_write assert the cycle after accept and hold, with
//             bus_addr/bus_sel/bus_wdata stable, until a posedge where bus_ack
//             is high (read data sampled on that same edge) or until TIMEOUT
//             strobe cycles have passed without ack. bus_ack is ignored when
//             no strobe is active.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake from execute
//   req_load, req_funct3         operation kind and RV32I width/sign code
//   req_addr, req_wdata, req_rd  byte address, store data, load destination
//   bus_addr/wdata/sel           word address, replicated data, lane enables
//   bus_read/bus_write/bus_ack   strobes and completion
//   bus_rdata                    read data, valid with bus_ack
//   rf_write/rf_addr/rf_data     register-file write port (one-cycle pulse)
//   fault                        one-cycle error pulse
//   state_dbg                    current FSM state (IDLE=0 ACCESS=1 WB=2 ERR=3)

module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rf_write,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        fault,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen on the last permitted strobe cycle.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_t state, state_next;

  logic          accept;
  logic          req_illegal;
  logic          req_misaligned;
  logic          req_bad;
  logic [3:0]    sel_c;
  logic [31:0]   wdata_c;
  logic [31:0]   rdata_shifted;
  logic [31:0]   load_c;

  // Latched request fields needed after accept.
  logic [1:0]    addr_lo_q;
  logic [2:0]    funct3_q;
  logic [4:0]    rd_q;
  logic          load_q;
  logic [CW-1:0] wait_cnt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign state_dbg = state;

  // Request classification.
  always_comb begin
    req_illegal = 1'b0;
    if (req_load) begin
      req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end else begin
      req_illegal = (req_funct3 >= 3'd3);
    end
    // funct3[1:0] encodes size for both loads and stores: 0=B, 1=H, 2=W.
    req_misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
    req_bad = req_illegal || req_misaligned;
  end

  // Lane enables and replicated store data.
  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        sel_c   = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        sel_c   = 4'b0011 << req_addr[1:0];
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        sel_c   = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  // Load alignment: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rdata_shifted = bus_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'd0:    load_c = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'd1:    load_c = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'd4:    load_c = {24'd0, rdata_shifted[7:0]};
      3'd5:    load_c = {16'd0, rdata_shifted[15:0]};
      default: load_c = rdata_shifted;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = req_bad ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (bus_ack) begin
          state_next = load_q ? WB : IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          state_next = ERR;
        end
      end
      WB:      state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_sel   <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      rf_write  <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      fault     <= 1'b0;
      addr_lo_q <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      rf_write <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_lo_q <= req_addr[1:0];
            funct3_q  <= req_funct3;
            rd_q      <= req_rd;
            load_q    <= req_load;
            wait_cnt  <= '0;
            if (req_bad) begin
              fault <= 1'b1;
            end else begin
              bus_read  <= req_load;
              bus_write <= !req_load;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_sel   <= sel_c;
              bus_wdata <= wdata_c;
            end
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            if (load_q) begin
              // Address/data still update for x0; only the enable is gated.
              rf_write <= (rd_q != 5'd0);
              rf_addr  <= rd_q;
              rf_data  <= load_c;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            fault     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit (TIMEOUT = 4).
// Each test task drives one scenario through run_op, which issues a request,
// plays the bus slave and records what the unit did; the task then compares
// those observations against values from the reference functions below.

module tb_load_store_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_read;
  logic        bus_write;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        fault;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];

  // Observations from the most recent run_op.
  int          obs_strobe, obs_rd_strobe, obs_wr_strobe;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_sel;
  logic        obs_unstable;
  int          obs_rf_cnt, obs_rf_cyc;
  logic [4:0]  obs_rf_addr;
  logic [31:0] obs_rf_data;
  int          obs_fault_cnt, obs_fault_cyc;
  int          obs_ack_cyc, obs_ready_cyc;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_read(bus_read), .bus_write(bus_write), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .fault(fault), .state_dbg(state_dbg)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic model_bad(input logic load, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    logic legal;
    if (load) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else      legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    if (!legal) return 1'b1;
    n = nbytes_of(f3);
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    n = nbytes_of(f3);
    off = addr % 4;
    v = rdata >> (8 * off);
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 1;
    v = v & mask;
    if (f3 < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    logic [7:0] s;
    n = nbytes_of(f3);
    s = ((8'd1 << n) - 8'd1) << (addr % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    int n;
    logic [31:0] w;
    n = nbytes_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % n) +: 8];
    return w;
  endfunction

  // ---------------- driver / bus slave ----------------
  // ack_delay: number of strobe cycles without ack before the acked one; <0 = never ack.
  // Cycle numbering: accept edge ends cycle 0.
  task automatic run_op(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int ack_delay, input logic [31:0] rdata);
    obs_strobe = 0; obs_rd_strobe = 0; obs_wr_strobe = 0; obs_unstable = 1'b0;
    obs_addr = '0; obs_sel = '0; obs_wdata = '0;
    obs_rf_cnt = 0; obs_rf_cyc = -1; obs_rf_addr = '0; obs_rf_data = '0;
    obs_fault_cnt = 0; obs_fault_cyc = -1; obs_ack_cyc = -1; obs_ready_cyc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_load = load; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (bus_read || bus_write) begin
        if (obs_strobe == 0) begin
          obs_addr = bus_addr; obs_sel = bus_sel; obs_wdata = bus_wdata;
        end else if (obs_addr !== bus_addr || obs_sel !== bus_sel || obs_wdata !== bus_wdata) begin
          obs_unstable = 1'b1;
        end
        if (bus_read) obs_rd_strobe++;
        if (bus_write) obs_wr_strobe++;
        obs_strobe++;
        if (ack_delay >= 0 && obs_strobe == ack_delay + 1) begin
          bus_ack = 1'b1; bus_rdata = rdata; obs_ack_cyc = cyc;
        end
      end
      if (rf_write) begin
        obs_rf_cnt++; obs_rf_cyc = cyc; obs_rf_addr = rf_addr; obs_rf_data = rf_data;
      end
      if (fault) begin
        obs_fault_cnt++; obs_fault_cyc = cyc;
      end
      if (req_ready) begin
        obs_ready_cyc = cyc;
        break;
      end
    end
    bus_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, bus_read, bus_write, rf_write, fault} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=10000", {req_ready, bus_read, bus_write, rf_write, fault});
    end
    total++;
    if ({bus_addr, bus_wdata, bus_sel, rf_addr, rf_data} !== '0) begin
      bad++; $display("FAIL reset_data got addr=%h wdata=%h sel=%b rf_addr=%0d rf_data=%h want all 0",
                      bus_addr, bus_wdata, bus_sel, rf_addr, rf_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw;
    run_op(1'b1, 3'd2, 32'h100, 32'h0, 5'd5, 2, 32'hDEADBEEF);
    total++;
    if (obs_sel !== 4'b1111 || obs_addr !== 32'h100 || obs_rd_strobe != 3 || obs_wr_strobe != 0) begin
      bad++; $display("FAIL lw_bus got sel=%b addr=%h rd=%0d wr=%0d want 1111 100 3 0",
                      obs_sel, obs_addr, obs_rd_strobe, obs_wr_strobe);
    end
    total++;
    if (obs_rf_cnt != 1 || obs_rf_cyc != obs_ack_cyc + 1 || obs_rf_cyc != 4) begin
      bad++; $display("FAIL lw_latency got rf_cnt=%0d rf_cyc=%0d ack_cyc=%0d want 1 4 3",
                      obs_rf_cnt, obs_rf_cyc, obs_ack_cyc);
    end
    total++;
    if (obs_rf_addr !== 5'd5 || obs_rf_data !== 32'hDEADBEEF || obs_unstable) begin
      bad++; $display("FAIL lw_data got rd=%0d data=%h unstable=%b want 5 deadbeef 0",
                      obs_rf_addr, obs_rf_data, obs_unstable);
    end
    total++;
    if (obs_ready_cyc != 5 || obs_fault_cnt != 0) begin
      bad++; $display("FAIL lw_ready got ready_cyc=%0d faults=%0d want 5 0", obs_ready_cyc, obs_fault_cnt);
    end
  endtask

  task automatic test_extend;
    logic [2:0]  f3s[4]   = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] addrs[4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] wants[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00003456};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, f3s[i], addrs[i], 32'h0, 5'd9, 0, 32'h80123456);
      total++;
      if (obs_rf_cnt != 1 || obs_rf_data !== wants[i] || obs_sel !== model_sel(f3s[i], addrs[i])) begin
        bad++; $display("FAIL extend_%0d got cnt=%0d data=%h sel=%b want 1 %h %b", i,
                        obs_rf_cnt, obs_rf_data, obs_sel, wants[i], model_sel(f3s[i], addrs[i]));
      end
    end
  endtask

  task automatic test_store;
    logic [31:0] prev_data;
    prev_data = rf_data;
    run_op(1'b0, 3'd0, 32'h101, 32'h000000AB, 5'd3, 1, 32'h0);
    total++;
    if (obs_wr_strobe != 2 || obs_rd_strobe != 0 || obs_addr !== 32'h100 ||
        obs_sel !== 4'b0010 || obs_wdata !== 32'hABABABAB) begin
      bad++; $display("FAIL sb_bus got wr=%0d rd=%0d addr=%h sel=%b wdata=%h want 2 0 100 0010 abababab",
                      obs_wr_strobe, obs_rd_strobe, obs_addr, obs_sel, obs_wdata);
    end
    total++;
    if (obs_rf_cnt != 0 || obs_ready_cyc != obs_ack_cyc + 1 || rf_data !== prev_data) begin
      bad++; $display("FAIL sb_done got rf_cnt=%0d ready=%0d ack=%0d rf_data=%h want 0 ack+1 hold %h",
                      obs_rf_cnt, obs_ready_cyc, obs_ack_cyc, rf_data, prev_data);
    end
  endtask

  task automatic test_fault;
    logic [2:0]  f3s[2]   = '{3'd2, 3'd3};
    logic [31:0] addrs[2] = '{32'h102, 32'h100};
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, f3s[i], addrs[i], 32'h0, 5'd4, 0, 32'h0);
      total++;
      if (obs_fault_cnt != 1 || obs_fault_cyc != 1 || obs_strobe != 0 ||
          obs_rf_cnt != 0 || obs_ready_cyc != 2) begin
        bad++; $display("FAIL fault_%0d got faults=%0d fcyc=%0d strobes=%0d rf=%0d ready=%0d want 1 1 0 0 2",
                        i, obs_fault_cnt, obs_fault_cyc, obs_strobe, obs_rf_cnt, obs_ready_cyc);
      end
    end
  endtask

  task automatic test_timeout;
    logic seen;
    run_op(1'b1, 3'd2, 32'h200, 32'h0, 5'd6, -1, 32'h0);
    total++;
    if (obs_rd_strobe != TIMEOUT || obs_fault_cnt != 1 || obs_fault_cyc != TIMEOUT + 1 ||
        obs_rf_cnt != 0 || obs_ready_cyc != TIMEOUT + 2) begin
      bad++; $display("FAIL timeout got strobes=%0d faults=%0d fcyc=%0d rf=%0d ready=%0d want %0d 1 %0d 0 %0d",
                      obs_rd_strobe, obs_fault_cnt, obs_fault_cyc, obs_rf_cnt, obs_ready_cyc,
                      TIMEOUT, TIMEOUT + 1, TIMEOUT + 2);
    end
    // Late ack while idle must do nothing.
    seen = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      if (rf_write || fault || bus_read || bus_write || !req_ready) seen = 1'b1;
    end
    bus_ack = 1'b0;
    total++;
    if (seen) begin
      bad++; $display("FAIL late_ack got activity=1 want 0");
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'd2; req_addr = 32'h300; req_rd = 5'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (bus_read !== 1'b1) begin
      bad++; $display("FAIL mid_strobe got bus_read=%b want 1", bus_read);
    end
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++;
    if ({bus_read, bus_write, rf_write, fault, req_ready} !== 5'b00001) begin
      bad++; $display("FAIL mid_reset got %b want 00001", {bus_read, bus_write, rf_write, fault, req_ready});
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rf_write || bus_read || fault) seen = 1'b1;
    end
    bus_ack = 1'b0;
    total++;
    if (seen) begin
      bad++; $display("FAIL mid_late_ack got activity=1 want 0");
    end
    // Load to x0 still completes but never writes.
    run_op(1'b1, 3'd2, 32'h400, 32'h0, 5'd0, 0, 32'h11112222);
    total++;
    if (obs_rf_cnt != 0 || obs_rd_strobe != 1 || obs_ready_cyc != 3) begin
      bad++; $display("FAIL rd0 got rf=%0d strobes=%0d ready=%0d want 0 1 3",
                      obs_rf_cnt, obs_rd_strobe, obs_ready_cyc);
    end
  endtask

  task automatic test_random;
    logic        load;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd;
    int          d, exp_strobe, exp_ready, exp_fault, exp_rf;
    logic        is_bad, timed_out;
    logic [31:0] exp_v;
    for (int n = 0; n < 60; n++) begin
      load  = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      d     = $urandom_range(0, 5);
      is_bad    = model_bad(load, f3, addr);
      timed_out = !is_bad && (d >= TIMEOUT);
      exp_fault = (is_bad || timed_out) ? 1 : 0;
      exp_strobe = is_bad ? 0 : (timed_out ? TIMEOUT : d + 1);
      exp_rf = (!is_bad && !timed_out && load && rd != 0) ? 1 : 0;
      if (is_bad) exp_ready = 2;
      else if (timed_out) exp_ready = TIMEOUT + 2;
      else exp_ready = load ? d + 3 : d + 2;
      if (exp_rf == 1) exp_q.push_back(model_load(f3, addr, rdata));
      run_op(load, f3, addr, wdata, rd, d, rdata);
      total++;
      if (obs_strobe != exp_strobe || obs_fault_cnt != exp_fault || obs_rf_cnt != exp_rf ||
          obs_ready_cyc != exp_ready || obs_unstable) begin
        bad++; $display("FAIL rand_flow_%0d got strobes=%0d faults=%0d rf=%0d ready=%0d unst=%b want %0d %0d %0d %0d 0",
                        n, obs_strobe, obs_fault_cnt, obs_rf_cnt, obs_ready_cyc, obs_unstable,
                        exp_strobe, exp_fault, exp_rf, exp_ready);
      end
      if (!is_bad) begin
        total++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_sel !== model_sel(f3, addr) ||
            (!load && obs_wdata !== model_wdata(f3, wdata)) ||
            (obs_rd_strobe != (load ? exp_strobe : 0))) begin
          bad++; $display("FAIL rand_bus_%0d got addr=%h sel=%b wdata=%h rds=%0d want %h %b %h",
                          n, obs_addr, obs_sel, obs_wdata, obs_rd_strobe, {addr[31:2], 2'b00},
                          model_sel(f3, addr), model_wdata(f3, wdata));
        end
      end
      if (exp_rf == 1 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        total++;
        if (obs_rf_data !== exp_v || obs_rf_addr !== rd) begin
          bad++; $display("FAIL rand_wb_%0d got rd=%0d data=%h want %0d %h", n, obs_rf_addr, obs_rf_data, rd, exp_v);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0; bus_ack = 1'b0; bus_rdata = '0;
    test_reset();
    test_lw();
    test_extend();
    test_store();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
